// File: rtl/cb_quantizer_8x8_if.sv
// Block-parallel bus between the DCT stage and the Cb quantizer.
interface cb_quantizer_8x8_if;
   logic               enable;
   logic signed [10:0] Z [0:7][0:7];
   logic signed [10:0] Q [0:7][0:7];
   logic               out_enable;

   // Producer side (DCT stage / bench)
   modport master (
      output enable,
      output Z,
      input  Q,
      input  out_enable
   );

   // Quantizer side
   modport slave (
      input  enable,
      input  Z,
      output Q,
      output out_enable
   );
endinterface

// File: rtl/cb_quantizer_8x8.sv
// Three-stage pipelined JPEG chroma quantizer for one 8x8 Cb block.
// Divides each coefficient by the chroma table through a 12-bit fixed-point
// reciprocal multiply, rounding with bit 11 of the product.
module cb_quantizer_8x8 (
   input  logic                clk,
   input  logic                rst,
   cb_quantizer_8x8_if.slave   bus
);

   localparam int unsigned ZW = 11;
   localparam int unsigned RW = 13;
   localparam int unsigned PW = 24;
   localparam int unsigned QTW = 7;
   localparam int unsigned FRAC = 12;

   // Standard JPEG chroma quantization table, row-major; unlisted entries are 99.
   function automatic logic [QTW-1:0] q_chroma(input int i, input int j);
      logic [QTW-1:0] qv;
      qv = QTW'(99);
      case (i)
         0: case (j)
               0: qv = QTW'(17);
               1: qv = QTW'(18);
               2: qv = QTW'(24);
               3: qv = QTW'(47);
               default: qv = QTW'(99);
            endcase
         1: case (j)
               0: qv = QTW'(18);
               1: qv = QTW'(21);
               2: qv = QTW'(26);
               3: qv = QTW'(66);
               default: qv = QTW'(99);
            endcase
         2: case (j)
               0: qv = QTW'(24);
               1: qv = QTW'(26);
               2: qv = QTW'(56);
               default: qv = QTW'(99);
            endcase
         3: case (j)
               0: qv = QTW'(47);
               1: qv = QTW'(66);
               default: qv = QTW'(99);
            endcase
         default: qv = QTW'(99);
      endcase
      return qv;
   endfunction

   // floor(4096 / q) for every value that appears in the table.
   function automatic logic [RW-1:0] recip_of(input logic [QTW-1:0] qv);
      logic [RW-1:0] r;
      case (qv)
         QTW'(17): r = RW'(240);
         QTW'(18): r = RW'(227);
         QTW'(21): r = RW'(195);
         QTW'(24): r = RW'(170);
         QTW'(26): r = RW'(157);
         QTW'(47): r = RW'(87);
         QTW'(56): r = RW'(73);
         QTW'(66): r = RW'(62);
         default:  r = RW'(41);
      endcase
      return r;
   endfunction

   logic                  v1;
   logic                  v2;
   logic signed [ZW-1:0]  z1   [0:7][0:7];
   logic signed [PW-1:0]  p2   [0:7][0:7];
   logic signed [PW-1:0]  prod [0:7][0:7];
   logic signed [ZW-1:0]  rnd  [0:7][0:7];

   // Lane products: sign-extended coefficient times zero-extended reciprocal.
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < 8; j++) begin
            prod[i][j] = PW'(z1[i][j]) *
                         $signed({(PW-RW)'(0), recip_of(q_chroma(i, j))});
         end
      end
   end

   // Lane rounding: arithmetic floor of P/4096 plus bit 11, truncated to 11 bits.
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < 8; j++) begin
            rnd[i][j] = ZW'((p2[i][j] >>> FRAC) +
                            $signed({(PW-1)'(0), p2[i][j][FRAC-1]}));
         end
      end
   end

   // Valid chain travelling alongside the data.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v1             <= 1'b0;
         v2             <= 1'b0;
         bus.out_enable <= 1'b0;
      end else begin
         v1             <= bus.enable;
         v2             <= v1;
         bus.out_enable <= v2;
      end
   end

   // S1: capture the input block on the enable edge only.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
               z1[i][j] <= '0;
      end else if (bus.enable) begin
         for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
               z1[i][j] <= bus.Z[i][j];
      end
   end

   // S2: register the 64 products when S1 holds a valid block.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
               p2[i][j] <= '0;
      end else if (v1) begin
         for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
               p2[i][j] <= prod[i][j];
      end
   end

   // S3: register the rounded result; it holds until the next block arrives.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
               bus.Q[i][j] <= '0;
      end else if (v2) begin
         for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
               bus.Q[i][j] <= rnd[i][j];
      end
   end

endmodule

// File: tb/tb_cb_quantizer_8x8.sv
// Directed bench for cb_quantizer_8x8: known blocks, timing, back-to-back and reset.
module tb_cb_quantizer_8x8;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;
   int   zin  [0:7][0:7];
   int   zin_b[0:7][0:7];

   cb_quantizer_8x8_if bus();

   cb_quantizer_8x8 dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Chroma quantization table written out independently of the design.
   function automatic int qval(input int i, input int j);
      int row0 [0:3];
      int row1 [0:3];
      int row2 [0:2];
      row0 = '{17, 18, 24, 47};
      row1 = '{18, 21, 26, 66};
      row2 = '{24, 26, 56};
      if (i == 0 && j < 4) return row0[j];
      if (i == 1 && j < 4) return row1[j];
      if (i == 2 && j < 3) return row2[j];
      if (i == 3 && j == 0) return 47;
      if (i == 3 && j == 1) return 66;
      return 99;
   endfunction

   // Reference arithmetic: floor(P/4096) + P[11], P = z * floor(4096/q).
   function automatic int model_q(input int z, input int i, input int j);
      int r;
      int p;
      r = 4096 / qval(i, j);
      p = z * r;
      return (p >>> 12) + ((p >> 11) & 1);
   endfunction

   task automatic drive_z(input int src [0:7][0:7]);
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++)
            bus.Z[i][j] = 11'(src[i][j]);
   endtask

   // Present a block for exactly one rising edge, returning at the following falling edge.
   task automatic start_block(input int src [0:7][0:7]);
      drive_z(src);
      bus.enable = 1'b1;
      @(negedge clk);
      bus.enable = 1'b0;
   endtask

   task automatic test_reset();
      int act;
      rst = 1'b0;
      bus.enable = 1'b0;
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++)
            bus.Z[i][j] = 11'(0);
      repeat (3) @(negedge clk);
      n_cmp++;
      if (bus.out_enable !== 1'b0) begin
         n_err++;
         $display("FAIL reset_out_enable got %b want 0", bus.out_enable);
      end
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++) begin
            act = bus.Q[i][j];
            n_cmp++;
            if (act !== 0) begin
               n_err++;
               $display("FAIL reset_q[%0d][%0d] got %0d want 0", i, j, act);
            end
         end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_all_max();
      int exp_hand [0:3][0:3];
      int act;
      int exp;
      exp_hand = '{'{60, 57, 42, 22}, '{57, 49, 39, 15},
                   '{42, 39, 18, 10}, '{22, 15, 10, 10}};
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++)
            zin[i][j] = 1023;
      start_block(zin);
      repeat (2) @(negedge clk);
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++) begin
            exp = (i < 4 && j < 4) ? exp_hand[i][j] : 10;
            act = bus.Q[i][j];
            n_cmp++;
            if (act !== exp) begin
               n_err++;
               $display("FAIL all_max q[%0d][%0d] got %0d want %0d", i, j, act, exp);
            end
         end
   endtask

   task automatic test_ramp();
      int act;
      int exp;
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++)
            zin[i][j] = 8 * i + j;
      start_block(zin);
      repeat (2) @(negedge clk);
      act = bus.Q[7][7];
      n_cmp++;
      if (act !== 1) begin
         n_err++;
         $display("FAIL ramp_q77 got %0d want 1", act);
      end
      act = bus.Q[0][1];
      n_cmp++;
      if (act !== 0) begin
         n_err++;
         $display("FAIL ramp_q01 got %0d want 0", act);
      end
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++) begin
            exp = model_q(zin[i][j], i, j);
            act = bus.Q[i][j];
            n_cmp++;
            if (act !== exp) begin
               n_err++;
               $display("FAIL ramp q[%0d][%0d] got %0d want %0d", i, j, act, exp);
            end
         end
   endtask

   task automatic test_checkerboard();
      int pi [0:5];
      int pj [0:5];
      int pe [0:5];
      int act;
      pi = '{0, 0, 1, 0, 0, 7};
      pj = '{0, 1, 0, 4, 5, 7};
      pe = '{60, -57, -57, 10, -10, 10};
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++)
            zin[i][j] = ((i + j) % 2 == 0) ? 1023 : -1024;
      start_block(zin);
      repeat (2) @(negedge clk);
      for (int k = 0; k < 6; k++) begin
         act = bus.Q[pi[k]][pj[k]];
         n_cmp++;
         if (act !== pe[k]) begin
            n_err++;
            $display("FAIL checker q[%0d][%0d] got %0d want %0d", pi[k], pj[k], act, pe[k]);
         end
      end
   endtask

   task automatic test_random_timing();
      int act;
      int exp;
      int cyc;
      for (int n = 0; n < 3; n++) begin
         for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
               zin[i][j] = int'($urandom_range(2047)) - 1024;
         start_block(zin);
         // Inputs wander after the sampling edge; the result must not follow them.
         for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
               bus.Z[i][j] = 11'(-zin[i][j] - 1);
         cyc = 1;
         while (bus.out_enable !== 1'b1 && cyc < 10) begin
            @(negedge clk);
            cyc++;
         end
         n_cmp++;
         if (cyc !== 3) begin
            n_err++;
            $display("FAIL random_latency got %0d want 3", cyc);
         end
         for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) begin
               exp = model_q(zin[i][j], i, j);
               act = bus.Q[i][j];
               n_cmp++;
               if (act !== exp) begin
                  n_err++;
                  $display("FAIL random q[%0d][%0d] got %0d want %0d", i, j, act, exp);
               end
            end
         @(negedge clk);
         n_cmp++;
         if (bus.out_enable !== 1'b0) begin
            n_err++;
            $display("FAIL random_pulse_width got %b want 0", bus.out_enable);
         end
         exp = model_q(zin[3][5], 3, 5);
         act = bus.Q[3][5];
         n_cmp++;
         if (act !== exp) begin
            n_err++;
            $display("FAIL random_hold q35 got %0d want %0d", act, exp);
         end
      end
   endtask

   task automatic test_back_to_back();
      int act;
      int exp;
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++) begin
            zin[i][j]   = 1023;
            zin_b[i][j] = -1024;
         end
      drive_z(zin);
      bus.enable = 1'b1;
      @(negedge clk);
      drive_z(zin_b);
      @(negedge clk);
      bus.enable = 1'b0;
      @(negedge clk);
      // First pulse carries block A.
      n_cmp++;
      if (bus.out_enable !== 1'b1) begin
         n_err++;
         $display("FAIL b2b_first_pulse got %b want 1", bus.out_enable);
      end
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++) begin
            exp = model_q(zin[i][j], i, j);
            act = bus.Q[i][j];
            n_cmp++;
            if (act !== exp) begin
               n_err++;
               $display("FAIL b2b_a q[%0d][%0d] got %0d want %0d", i, j, act, exp);
            end
         end
      @(negedge clk);
      n_cmp++;
      if (bus.out_enable !== 1'b1) begin
         n_err++;
         $display("FAIL b2b_second_pulse got %b want 1", bus.out_enable);
      end
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++) begin
            exp = model_q(zin_b[i][j], i, j);
            act = bus.Q[i][j];
            n_cmp++;
            if (act !== exp) begin
               n_err++;
               $display("FAIL b2b_b q[%0d][%0d] got %0d want %0d", i, j, act, exp);
            end
         end
      act = bus.Q[0][0];
      n_cmp++;
      if (act !== -60) begin
         n_err++;
         $display("FAIL b2b_b_q00 got %0d want -60", act);
      end
      @(negedge clk);
      n_cmp++;
      if (bus.out_enable !== 1'b0) begin
         n_err++;
         $display("FAIL b2b_after got %b want 0", bus.out_enable);
      end
   endtask

   task automatic test_reset_midflight();
      int act;
      int exp;
      int pulses;
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++)
            zin[i][j] = 500 - 16 * (i + j);
      start_block(zin);
      rst = 1'b0;
      pulses = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (bus.out_enable === 1'b1) pulses++;
      end
      n_cmp++;
      if (pulses !== 0) begin
         n_err++;
         $display("FAIL midreset_pulses got %0d want 0", pulses);
      end
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++) begin
            act = bus.Q[i][j];
            n_cmp++;
            if (act !== 0) begin
               n_err++;
               $display("FAIL midreset_q[%0d][%0d] got %0d want 0", i, j, act);
            end
         end
      rst = 1'b1;
      @(negedge clk);
      pulses = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (bus.out_enable === 1'b1) pulses++;
      end
      n_cmp++;
      if (pulses !== 0) begin
         n_err++;
         $display("FAIL midreset_stale_pulse got %0d want 0", pulses);
      end
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++)
            zin[i][j] = -300 + 9 * i - 7 * j;
      start_block(zin);
      @(negedge clk);
      n_cmp++;
      if (bus.out_enable !== 1'b0) begin
         n_err++;
         $display("FAIL postreset_early got %b want 0", bus.out_enable);
      end
      @(negedge clk);
      n_cmp++;
      if (bus.out_enable !== 1'b1) begin
         n_err++;
         $display("FAIL postreset_pulse got %b want 1", bus.out_enable);
      end
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++) begin
            exp = model_q(zin[i][j], i, j);
            act = bus.Q[i][j];
            n_cmp++;
            if (act !== exp) begin
               n_err++;
               $display("FAIL postreset q[%0d][%0d] got %0d want %0d", i, j, act, exp);
            end
         end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst = 1'b0;
      bus.enable = 1'b0;
      @(negedge clk);
      test_reset();
      test_all_max();
      test_ramp();
      test_checkerboard();
      test_random_timing();
      test_back_to_back();
      test_reset_midflight();
      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
